// File: rtl/out_stream_pkg.sv
// Shared types and helpers for the output stream arbiter: state encoding,
// word geometry and the channel-count to beat-count conversion.
package out_stream_pkg;

    localparam int MAC_WIDTH  = 256;
    localparam int BEAT_WIDTH = 32;
    localparam int BEATS_MAX  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // ceil(ch/32) clamped to 1..BEATS_MAX; the 8-bit sum cannot overflow for 12-bit ch.
    function automatic logic [3:0] calc_beats(input logic [11:0] ch);
        logic [7:0] sum;
        sum = {1'b0, ch[11:5]} + {7'd0, |ch[4:0]};
        if (sum == 8'd0) begin
            return 4'd1;
        end else if (sum > 8'(BEATS_MAX)) begin
            return 4'(BEATS_MAX);
        end else begin
            return sum[3:0];
        end
    endfunction

endpackage

// File: rtl/out_word_serializer.sv
// Holds one accepted 256-bit word and emits it as 32-bit AXIS beats, lowest
// beat first, with all stream outputs driven straight from flops.
module out_word_serializer
    import out_stream_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [MAC_WIDTH-1:0] load_data,
    input  logic                 load_last,
    input  logic [3:0]           load_beats,
    output logic                 busy,
    output logic                 word_done,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tlast
);

    logic [MAC_WIDTH-1:0] word_q;
    logic [2:0]           beat_cnt_q;
    logic [3:0]           nb_q;
    logic                 last_q;
    logic                 tvalid_q;
    logic                 tlast_q;
    logic                 hs;
    logic                 final_beat;
    logic                 next_final;

    assign hs         = tvalid_q & m_axis_tready;
    assign final_beat = ({1'b0, beat_cnt_q} == (nb_q - 4'd1));
    assign next_final = (({1'b0, beat_cnt_q} + 4'd2) == nb_q);
    assign word_done  = hs & final_beat;

    // The word shifts down one beat per handshake, so tdata is always word_q[31:0].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q     <= '0;
            beat_cnt_q <= '0;
            nb_q       <= 4'd1;
            last_q     <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
        end else if (load) begin
            word_q     <= load_data;
            beat_cnt_q <= '0;
            nb_q       <= load_beats;
            last_q     <= load_last;
            tvalid_q   <= 1'b1;
            tlast_q    <= (load_beats == 4'd1) && load_last;
        end else if (hs) begin
            if (final_beat) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end else begin
                beat_cnt_q <= beat_cnt_q + 3'd1;
                word_q     <= word_q >> BEAT_WIDTH;
                tlast_q    <= next_final && last_q;
            end
        end
    end

    assign busy          = tvalid_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = word_q[BEAT_WIDTH-1:0];
    assign m_axis_tlast  = tlast_q;

endmodule

// File: rtl/out_stream_arbiter.sv
// Round-robin arbiter sharing one 32-bit AXIS master between the convolution
// (req0) and pooling (req1) result paths, one 256-bit word per grant.
// Handshakes: a transfer happens on any rising clk edge where valid && ready;
// the producer holds valid and payload stable until then, and the AXIS side
// never drops tvalid or changes tdata/tlast while waiting for tready.
module out_stream_arbiter
    import out_stream_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [MAC_WIDTH-1:0] req0_data,
    input  logic [11:0]          req0_ch_size,
    input  logic                 req0_last,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [MAC_WIDTH-1:0] req1_data,
    input  logic [11:0]          req1_ch_size,
    input  logic                 req1_last,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 done0,
    output logic                 done1,
    output logic                 grant,
    output state_t               dbg_state
);

    state_t state_q, state_d;
    logic   prio_q;
    logic   grant_q;
    logic   done0_q, done1_q;
    logic   sel;
    logic   idle;
    logic   accept;
    logic   busy;
    logic   word_done;

    // Priority holder wins when it is valid; otherwise the other one may go.
    always_comb begin
        sel = prio_q;
        if (prio_q ? req1_valid : req0_valid) begin
            sel = prio_q;
        end else if (prio_q ? req0_valid : req1_valid) begin
            sel = ~prio_q;
        end
    end

    assign idle       = (state_q == IDLE) && !busy;
    assign req0_ready = idle && (sel == 1'b0) && req0_valid;
    assign req1_ready = idle && (sel == 1'b1) && req1_valid;
    assign accept     = req0_ready | req1_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: if (word_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done0_q <= word_done && (grant_q == 1'b0);
            done1_q <= word_done && (grant_q == 1'b1);
            if (accept) grant_q <= sel;
            if (word_done) prio_q <= ~grant_q;
        end
    end

    out_word_serializer u_ser (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (accept),
        .load_data     (sel ? req1_data : req0_data),
        .load_last     (sel ? req1_last : req0_last),
        .load_beats    (calc_beats(sel ? req1_ch_size : req0_ch_size)),
        .busy          (busy),
        .word_done     (word_done),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

    assign done0     = done0_q;
    assign done1     = done1_q;
    assign grant     = grant_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_out_stream_arbiter.sv
// Scoreboard bench for out_stream_arbiter: each test pushes the beats it
// expects ({grant, tlast, tdata}) and a negedge monitor pops them on handshakes.
module tb_out_stream_arbiter;
    import out_stream_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [255:0] req0_data = '0, req1_data = '0;
    logic [11:0]  req0_ch_size = '0, req1_ch_size = '0;
    logic         req0_last = 1'b0, req1_last = 1'b0;
    logic         m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
    logic [31:0]  m_axis_tdata;
    logic         done0, done1, grant;
    state_t       dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [33:0] exp_q[$];
    int hs_cyc[$];
    int done0_cnt = 0, done1_cnt = 0, done0_cyc = -1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;

    out_stream_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_ch_size(req0_ch_size), .req0_last(req0_last),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_ch_size(req1_ch_size), .req1_last(req1_last),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .done0(done0), .done1(done1), .grant(grant), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        rst_n = 1'b0;
        m_axis_tready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        hs_cyc.delete();
        done0_cnt = 0;
        done1_cnt = 0;
        done0_cyc = -1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (done0) begin
                done0_cnt <= done0_cnt + 1;
                done0_cyc <= cyc;
            end
            if (done1) done1_cnt <= done1_cnt + 1;
            if (prev_stall) begin
                total++;
                if (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l);
                end
            end
            prev_stall <= m_axis_tvalid && !m_axis_tready;
            prev_d     <= m_axis_tdata;
            prev_l     <= m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                logic [33:0] e;
                hs_cyc.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: got g=%b l=%b d=%h want none",
                             grant, m_axis_tlast, m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({grant, m_axis_tlast, m_axis_tdata} !== e) begin
                        bad++;
                        $display("FAIL beat: got g=%b l=%b d=%h want g=%b l=%b d=%h",
                                 grant, m_axis_tlast, m_axis_tdata, e[33], e[32], e[31:0]);
                    end
                end
            end
        end
    end

    function automatic int model_beats(input int ch);
        int nb;
        nb = (ch + 31) / 32;
        if (nb < 1) nb = 1;
        if (nb > 8) nb = 8;
        return nb;
    endfunction

    task automatic push_word(input logic g, input logic [255:0] d, input int ch, input logic lst);
        int nb;
        nb = model_beats(ch);
        for (int k = 0; k < nb; k++)
            exp_q.push_back({g, (k == nb - 1) && lst, d[32*k +: 32]});
    endtask

    // driver: present a word and wait (bounded) for acceptance
    task automatic drive_req(input int n, input logic [255:0] d, input logic [11:0] ch,
                             input logic lst, input bit hold);
        bit ok;
        ok = 0;
        if (n == 0) begin
            req0_data = d; req0_ch_size = ch; req0_last = lst; req0_valid = 1'b1;
        end else begin
            req1_data = d; req1_ch_size = ch; req1_last = lst; req1_valid = 1'b1;
        end
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if ((n == 0) ? req0_ready : req1_ready) ok = 1;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout: req%0d got ready=0 want ready=1", n);
        end
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && i < 2000) begin
            @(posedge clk);
            i++;
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d beats pending want 0", exp_q.size());
        end
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom();
        return w;
    endfunction

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, done0, done1, grant,
             req0_ready, req1_ready, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset_vals: got v=%b d=%h l=%b d0=%b d1=%b g=%b r0=%b r1=%b st=%b want all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, done0, done1, grant,
                     req0_ready, req1_ready, dbg_state);
        end
    endtask

    task automatic test_single();
        logic [255:0] d;
        do_reset();
        d = rand_word();
        push_word(1'b0, d, 64, 1'b0);
        drive_req(0, d, 12'd64, 1'b0, 0);
        wait_drain();
        total++;
        if (hs_cyc.size() != 2 || done0_cnt != 1 || done1_cnt != 0) begin
            bad++;
            $display("FAIL single_count: got beats=%0d d0=%0d d1=%0d want 2 1 0",
                     hs_cyc.size(), done0_cnt, done1_cnt);
        end
        total++;
        if (hs_cyc.size() == 2 && done0_cyc != hs_cyc[1] + 1) begin
            bad++;
            $display("FAIL single_done_time: got cyc=%0d want %0d", done0_cyc, hs_cyc[1] + 1);
        end
    endtask

    task automatic test_conflict();
        logic [255:0] d0, d1;
        do_reset();
        d0 = rand_word();
        d1 = rand_word();
        push_word(1'b0, d0, 256, 1'b0);
        push_word(1'b1, d1, 256, 1'b1);
        fork
            drive_req(0, d0, 12'd256, 1'b0, 0);
            drive_req(1, d1, 12'd256, 1'b1, 0);
        join
        wait_drain();
        total++;
        if (hs_cyc.size() != 16) begin
            bad++;
            $display("FAIL conflict_beats: got %0d want 16", hs_cyc.size());
        end else if (hs_cyc[8] - hs_cyc[7] != 2 || hs_cyc[7] - hs_cyc[0] != 7) begin
            bad++;
            $display("FAIL conflict_gap: got gap=%0d span=%0d want 2 7",
                     hs_cyc[8] - hs_cyc[7], hs_cyc[7] - hs_cyc[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] d;
        logic pat[6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        d = rand_word();
        push_word(1'b0, d, 96, 1'b1);
        m_axis_tready = 1'b0;
        drive_req(0, d, 12'd96, 1'b1, 0);
        for (int i = 0; i < 6; i++) begin
            m_axis_tready = pat[i];
            @(posedge clk);
            #1;
        end
        m_axis_tready = 1'b1;
        wait_drain();
        total++;
        if (hs_cyc.size() != 3) begin
            bad++;
            $display("FAIL bp_beats: got %0d want 3", hs_cyc.size());
        end
    endtask

    task automatic test_boundaries();
        int chs[3];
        logic lsts[3];
        logic [255:0] d;
        chs  = '{0, 33, 4095};
        lsts = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            d = rand_word();
            push_word(1'b0, d, chs[i], lsts[i]);
            drive_req(0, d, 12'(chs[i]), lsts[i], 0);
            wait_drain();
            total++;
            if (hs_cyc.size() != model_beats(chs[i])) begin
                bad++;
                $display("FAIL bound_beats ch=%0d: got %0d want %0d",
                         chs[i], hs_cyc.size(), model_beats(chs[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] d, a, b;
        do_reset();
        d = rand_word();
        push_word(1'b0, d, 256, 1'b1);
        void'(exp_q.pop_back()); void'(exp_q.pop_back()); void'(exp_q.pop_back());
        void'(exp_q.pop_back()); void'(exp_q.pop_back()); void'(exp_q.pop_back());
        drive_req(0, d, 12'd256, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        m_axis_tready = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, done0, done1, grant, dbg_state} !== '0) begin
            bad++;
            $display("FAIL midreset_vals: got v=%b d=%h l=%b d0=%b d1=%b g=%b st=%b want all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, done0, done1, grant, dbg_state);
        end
        total++;
        if (hs_cyc.size() != 2) begin
            bad++;
            $display("FAIL midreset_beats: got %0d want 2", hs_cyc.size());
        end
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        exp_q.delete();
        a = rand_word();
        b = rand_word();
        push_word(1'b0, a, 32, 1'b0);
        push_word(1'b1, b, 32, 1'b1);
        fork
            drive_req(1, b, 12'd32, 1'b1, 0);
            drive_req(0, a, 12'd32, 1'b0, 0);
        join
        wait_drain();
    endtask

    task automatic test_fairness();
        logic [255:0] w0[5], w1[5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            w0[i] = rand_word();
            w1[i] = rand_word();
            push_word(1'b0, w0[i], $urandom_range(1, 256), 1'b0);
            void'(exp_q.pop_back());
        end
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            push_word(1'b0, w0[i], 32, 1'b0);
            push_word(1'b1, w1[i], 32, (i == 4));
        end
        fork
            begin
                for (int i = 0; i < 5; i++) drive_req(0, w0[i], 12'd32, 1'b0, i < 4);
            end
            begin
                for (int j = 0; j < 5; j++) drive_req(1, w1[j], 12'd32, (j == 4), j < 4);
            end
        join
        wait_drain();
        total++;
        if (done0_cnt != 5 || done1_cnt != 5) begin
            bad++;
            $display("FAIL fair_done: got d0=%0d d1=%0d want 5 5", done0_cnt, done1_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_backpressure();
        test_boundaries();
        test_reset_mid();
        test_fairness();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
